// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. It owns the architectural HI/LO
// registers and holds busy for a fixed number of cycles per operation.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdOp_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e            state;
  state_e            stateNext;
  logic [CNT_W-1:0]  counter;
  logic [31:0]       pendHi;
  logic [31:0]       pendLo;
  logic              pendValid;

  // Operand preparation and result datapath, evaluated in the launch cycle.
  logic        isMul;
  logic        isSigned;
  logic        launch;
  logic        divByZero;
  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;
  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] quotMag;
  logic [31:0] remMag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] launchHi;
  logic [31:0] launchLo;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; an incomplete always_comb would infer a latch.
  always_comb begin
    isMul     = (op == OP_MULT) || (op == OP_MULTU);
    isSigned  = (op == OP_MULT) || (op == OP_DIV);
    launch    = start && !op[2] && (state == IDLE);
    divByZero = (B == 32'd0);

    // Low 64 bits of the product of sign/zero-extended operands are exact.
    mulA    = isSigned ? {{32{A[31]}}, A} : {32'd0, A};
    mulB    = isSigned ? {{32{B[31]}}, B} : {32'd0, B};
    product = mulA * mulB;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    negA    = isSigned && A[31];
    negB    = isSigned && B[31];
    magA    = negA ? (~A + 32'd1) : A;
    magB    = negB ? (~B + 32'd1) : B;
    quotMag = 32'd0;
    remMag  = 32'd0;
    if (!divByZero) begin
      quotMag = magA / magB;
      remMag  = magA % magB;
    end
    quot = (negA ^ negB) ? (~quotMag + 32'd1) : quotMag;
    rem  = negA ? (~remMag + 32'd1) : remMag;

    launchHi = isMul ? product[63:32] : rem;
    launchLo = isMul ? product[31:0]  : quot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (launch) stateNext = RUN;
      RUN:     if (counter == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the pending result is reset too, so an aborted operation can
      // never leak stale data into HI/LO after reset is released.
      counter   <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendValid <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else if (state == IDLE) begin
      if (launch) begin
        pendHi    <= launchHi;
        pendLo    <= launchLo;
        pendValid <= isMul || !divByZero;
        counter   <= isMul ? MULT_LOAD : DIV_LOAD;
      end
      if (op == OP_MTHI) HI <= A;
      if (op == OP_MTLO) LO <= A;
    end else begin
      if (counter == '0) begin
        if (pendValid) begin
          HI <= pendHi;
          LO <= pendLo;
        end
      end else begin
        counter <= counter - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: HI/LO results, busy length,
// MTHI/MTLO, ignored starts and asynchronous abort.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NONE  = 3'd6;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(rstN),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse for one cycle; busy must still be low in that cycle.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    check("busy_in_start_cycle", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    op    = OP_NONE;
  endtask

  // Count remaining busy cycles (bounded) and compare with the expected length.
  task automatic waitDone(input string tag, input int expN);
    int cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      step();
    end
    check(tag, 32'(cnt), 32'(expN));
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int n,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    launch(o, a, b);
    waitDone({tag, "_busy"}, n);
    check({tag, "_hi"}, HI, expHi);
    check({tag, "_lo"}, LO, expLo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN  = 1'b0;
    start = 1'b0;
    op    = OP_NONE;
    A     = '0;
    B     = '0;
    repeat (2) step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    rstN = 1'b1;
    step();

    // MTHI then MTLO on consecutive cycles, never busy
    op = OP_MTHI; A = 32'h0000_1234;
    step();
    check("mthi_busy", 32'(busy), 32'd0);
    op = OP_MTLO; A = 32'h0000_ABCD;
    step();
    op = OP_NONE; A = '0;
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mt_hi", HI, 32'h0000_1234);
    check("mt_lo", LO, 32'h0000_ABCD);

    runOp("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,        5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
    runOp("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_negdiv", OP_DIV,   32'd7,        32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    runOp("divu",       OP_DIVU,  32'd7,        32'd2,         10, 32'h0000_0001, 32'h0000_0003);
    runOp("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // Divide by zero leaves HI/LO untouched
    op = OP_MTHI; A = 32'h55;
    step();
    op = OP_MTLO; A = 32'h55;
    step();
    op = OP_NONE;
    runOp("divu_zero", OP_DIVU, 32'd1234, 32'd0, 10, 32'h55, 32'h55);
    runOp("div_zero",  OP_DIV,  32'hFFFF_0000, 32'd0, 10, 32'h55, 32'h55);

    // MTHI presented while busy is ignored
    launch(OP_MULTU, 32'd2, 32'd3);
    step();
    op = OP_MTHI; A = 32'hDEAD;
    step();
    op = OP_NONE;
    waitDone("mt_in_busy_busy", 3);
    check("mt_in_busy_hi", HI, 32'd0);
    check("mt_in_busy_lo", LO, 32'd6);

    // start with op 4..7 never launches; op 4 still writes HI
    launch(OP_NONE, 32'd9, 32'd9);
    check("start_none_busy", 32'(busy), 32'd0);
    launch(3'd7, 32'd9, 32'd9);
    check("start_7_busy", 32'(busy), 32'd0);
    launch(OP_MTHI, 32'h77, 32'd0);
    check("start_mthi_busy", 32'(busy), 32'd0);
    check("start_mthi_hi", HI, 32'h77);
    check("start_mthi_lo", LO, 32'd6);

    // Second start during busy cycle 3 is ignored
    launch(OP_DIV, 32'd100, 32'd7);
    step();
    step();
    start = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd2;
    step();
    start = 1'b0; op = OP_NONE;
    waitDone("overlap_busy", 7);
    check("overlap_hi", HI, 32'd2);
    check("overlap_lo", LO, 32'd14);

    // Reset low at busy cycle 6 aborts at once
    launch(OP_DIV, 32'd100, 32'd3);
    step();
    step();
    start = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd2;
    step();
    start = 1'b0; op = OP_NONE;
    step();
    step();
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    step();
    rstN = 1'b1;
    repeat (15) step();
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_hi_after", HI, 32'd0);
    check("abort_lo_after", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
